unison_readout_capture: RTL and testbench

Captures the serial counter readout that the unison wavelet cores drive onto the shared `read_out_I[1:0]` / `read_out_Q[1:0]` lines after accumulation ends. Sits directly downstream of the dual-core chain on the `clk_master` domain. It deserialises one frame per lane into parallel words, tags each word with its lane, and buffers them in a small FIFO. The RISC drains the FIFO through a valid/ready handshake.

---
 rtl/unison_readout_pkg.sv | 32 +++
 rtl/unison_readout_fifo.sv | 61 ++++++
 rtl/unison_readout_capture.sv | 173 +++++++++++++++++
 tb/tb_unison_readout_capture.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unison_readout_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : unison_readout_pkg
//  Description : Shared types and constants for the unison readout capture
//                block: FSM state encoding, lane identifiers, word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package unison_readout_pkg;

    // Capture sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        SHIFT = 2'd2,
        PUSH  = 2'd3
    } state_t;

    // Lane identifiers carried in the upper bits of every FIFO word
    localparam logic [1:0] LANE_I0 = 2'd0;
    localparam logic [1:0] LANE_I1 = 2'd1;
    localparam logic [1:0] LANE_Q0 = 2'd2;
    localparam logic [1:0] LANE_Q1 = 2'd3;

    localparam int NUM_LANES = 4;

    // Stored word is the frame plus a 2-bit lane tag
    function automatic int word_width(input int frame_bits);
        return frame_bits + 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/unison_readout_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : unison_readout_fifo
//  Description : Show-ahead synchronous FIFO. The head entry is presented
//                combinationally from the storage registers; a push into a
//                full FIFO is dropped unless a pop frees the slot in the
//                same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module unison_readout_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 18
) (
    input  logic             clk_master,
    input  logic             rstb,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; both may advance in the same cycle
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage; cleared on reset so the head reads zero while empty
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/unison_readout_capture.sv
`default_nettype none
// ============================================================================
//  Module      : unison_readout_capture
//  Description : Deserialises one readout frame per lane from the shared
//                read_out_I/read_out_Q lines after ud_en falls, tags each
//                word with its lane and queues it in a show-ahead FIFO that
//                the RISC drains over a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module unison_readout_capture
    import unison_readout_pkg::*;
#(
    parameter int FRAME_BITS  = 16,
    parameter int START_DELAY = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                  clk_master,
    input  logic                  rstb,
    input  logic                  ud_en,
    input  logic [1:0]            read_out_I,
    input  logic [1:0]            read_out_Q,
    input  logic                  rd_ready,
    output logic                  rd_valid,
    output logic [FRAME_BITS+1:0] rd_data,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  aborted,
    output logic                  overflow
);

    localparam int              WORD_W     = word_width(FRAME_BITS);
    localparam int              BIT_W      = $clog2(FRAME_BITS);
    localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
    localparam logic [3:0]      DELAY_LOAD = 4'(START_DELAY);

    state_t                 state_q;
    state_t                 state_d;
    logic                   ud_en_q;
    logic                   armed;
    logic                   fall;
    logic [3:0]             delay_cnt;
    logic [BIT_W-1:0]       bit_cnt;
    logic [1:0]             lane_cnt;
    logic [FRAME_BITS-1:0]  shreg [NUM_LANES];
    logic [NUM_LANES-1:0]   lines;

    logic                   push;
    logic [WORD_W-1:0]      push_word;
    logic                   busy_d;
    logic                   frame_done_d;
    logic                   aborted_d;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   pop;
    logic                   drop;

    // Lane n sits at bit n: I lines are lanes 0/1, Q lines are lanes 2/3
    assign lines = {read_out_Q, read_out_I};

    // A fall only counts once ud_en has been seen high since reset, so a
    // line held low through reset release does not start a spurious frame.
    assign fall = ud_en_q & ~ud_en & armed;

    // FSM state register
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (fall) state_d = (START_DELAY == 0) ? SHIFT : WAIT;
            end
            WAIT: begin
                // Counter is loaded with START_DELAY; leaving at 1 makes the
                // first SHIFT sample land START_DELAY+1 edges after the fall.
                if (ud_en)                  state_d = IDLE;
                else if (delay_cnt <= 4'd1) state_d = SHIFT;
            end
            SHIFT: begin
                if (ud_en)                    state_d = IDLE;
                else if (bit_cnt == LAST_BIT) state_d = PUSH;
            end
            PUSH: begin
                if (lane_cnt == LANE_Q1) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: FIFO write strobe/data and next values of the status flags
    always_comb begin
        push         = (state_q == PUSH);
        push_word    = {lane_cnt, shreg[lane_cnt]};
        frame_done_d = (state_q == PUSH) && (lane_cnt == LANE_Q1);
        aborted_d    = ((state_q == WAIT) || (state_q == SHIFT)) && ud_en;
        busy_d       = (state_d != IDLE);
    end

    // Edge detector, delay/bit/lane counters
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            ud_en_q   <= 1'b1;
            armed     <= 1'b0;
            delay_cnt <= '0;
            bit_cnt   <= '0;
            lane_cnt  <= LANE_I0;
        end else begin
            ud_en_q <= ud_en;
            if (ud_en) armed <= 1'b1;

            case (state_q)
                IDLE:    delay_cnt <= DELAY_LOAD;
                WAIT:    delay_cnt <= delay_cnt - 4'd1;
                default: delay_cnt <= delay_cnt;
            endcase

            bit_cnt  <= (state_q == SHIFT) ? bit_cnt + BIT_ONE : '0;
            lane_cnt <= (state_q == PUSH)  ? lane_cnt + 2'd1  : LANE_I0;
        end
    end

    // Per-lane deserialisers: MSB arrives first, new bit enters at the LSB
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            for (int n = 0; n < NUM_LANES; n++) shreg[n] <= '0;
        end else if (state_q == SHIFT) begin
            for (int n = 0; n < NUM_LANES; n++)
                shreg[n] <= {shreg[n][FRAME_BITS-2:0], lines[n]};
        end
    end

    // A push is lost only when full and no pop frees a slot in the same cycle
    assign pop  = rd_valid & rd_ready;
    assign drop = push & fifo_full & ~pop;

    // Registered status outputs; overflow stays set until reset
    always_ff @(posedge clk_master or negedge rstb) begin
        if (!rstb) begin
            busy       <= 1'b0;
            frame_done <= 1'b0;
            aborted    <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            busy       <= busy_d;
            frame_done <= frame_done_d;
            aborted    <= aborted_d;
            overflow   <= overflow | drop;
        end
    end

    unison_readout_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk_master (clk_master),
        .rstb       (rstb),
        .push       (push),
        .push_data  (push_word),
        .pop        (rd_ready),
        .rd_data    (rd_data),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    assign rd_valid = ~fifo_empty;

endmodule
`default_nettype wire

// File: tb/tb_unison_readout_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unison_readout_capture
//  Description : Self-checking bench for unison_readout_capture. A
//                cycle-level reference model derived from the frame timing
//                rules (fall edge E, sample and write offsets) tracks the
//                expected FIFO contents and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unison_readout_capture;

    localparam int FB    = 16;
    localparam int SD    = 2;
    localparam int DEPTH = 8;
    localparam int NONE  = 1000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (START_DELAY = 2)
    logic        rstb, ud_en, rd_ready;
    logic [1:0]  read_out_I, read_out_Q;
    logic        rd_valid, busy, frame_done, aborted, overflow;
    logic [17:0] rd_data;

    // Second DUT with START_DELAY = 0
    logic        ud_z, rdy_z;
    logic [1:0]  ri_z, rq_z;
    logic        rv_z, busy_z, fd_z, ab_z, ov_z;
    logic [17:0] rdat_z;

    unison_readout_capture #(.FRAME_BITS(FB), .START_DELAY(SD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_master (clk),        .rstb      (rstb),
        .ud_en      (ud_en),      .read_out_I(read_out_I),
        .read_out_Q (read_out_Q), .rd_ready  (rd_ready),
        .rd_valid   (rd_valid),   .rd_data   (rd_data),
        .busy       (busy),       .frame_done(frame_done),
        .aborted    (aborted),    .overflow  (overflow)
    );

    unison_readout_capture #(.FRAME_BITS(FB), .START_DELAY(0), .FIFO_DEPTH(DEPTH)) dut_z (
        .clk_master (clk),    .rstb      (rstb),
        .ud_en      (ud_z),   .read_out_I(ri_z),
        .read_out_Q (rq_z),   .rd_ready  (rdy_z),
        .rd_valid   (rv_z),   .rd_data   (rdat_z),
        .busy       (busy_z), .frame_done(fd_z),
        .aborted    (ab_z),   .overflow  (ov_z)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rand_ready = 0;

    // ---------------- reference model ----------------
    logic [17:0] m_q[$];
    logic [15:0] m_acc [4];
    bit          m_active, m_armed, m_prev, m_ovf, m_done, m_abort;
    int          m_e;
    logic [17:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic logic line_of(input int n);
        return (n < 2) ? read_out_I[n] : read_out_Q[n-2];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 0; m_armed = 0; m_prev = 1;
        m_ovf = 0; m_done = 0; m_abort = 0; m_e = 0;
        for (int n = 0; n < 4; n++) m_acc[n] = '0;
    endtask

    // Evaluated at each rising edge with the inputs present at that edge
    task automatic model_edge();
        int  t;
        int  lane;
        bit  pop;
        bit  push_ok;
        lane = -1; m_done = 0; m_abort = 0;
        if (m_active) begin
            t = cyc - m_e;
            if (t >= 1 && t <= SD + FB && ud_en) begin
                m_active = 0; m_abort = 1;
            end else begin
                if (t >= SD + 1 && t <= SD + FB)
                    for (int n = 0; n < 4; n++)
                        if (line_of(n)) m_acc[n] = m_acc[n] | (16'(1) << (FB - 1 - (t - SD - 1)));
                if (t >= SD + FB + 1 && t <= SD + FB + 4) lane = t - SD - FB - 1;
                if (t == SD + FB + 4) begin m_active = 0; m_done = 1; end
            end
        end else if (m_armed && m_prev && !ud_en) begin
            m_active = 1; m_e = cyc;
            for (int n = 0; n < 4; n++) m_acc[n] = '0;
        end
        m_prev = ud_en;
        if (ud_en) m_armed = 1;

        pop     = (m_q.size() > 0) && rd_ready;
        push_ok = 0;
        if (lane >= 0) begin
            if (m_q.size() < DEPTH || pop) push_ok = 1;
            else                           m_ovf = 1;
        end
        if (pop) void'(m_q.pop_front());
        if (push_ok) m_q.push_back({2'(lane), m_acc[lane]});
    endtask

    task automatic cmp_outputs();
        chk("busy",       busy,       m_active);
        chk("frame_done", frame_done, m_done);
        chk("aborted",    aborted,    m_abort);
        chk("overflow",   overflow,   m_ovf);
        chk("rd_valid",   rd_valid,   m_q.size() > 0);
        if (m_q.size() > 0) chk("rd_data", rd_data, m_q[0]);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        if (rstb) model_edge();
        #1;
        cmp_outputs();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_valid"},   rd_valid,   0);
        chk({tag, "_rd_data"},    rd_data,    0);
        chk({tag, "_busy"},       busy,       0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_aborted"},    aborted,    0);
        chk({tag, "_overflow"},   overflow,   0);
    endtask

    task automatic set_line(input int n, input logic b);
        if (n < 2) read_out_I[n] = b;
        else       read_out_Q[n-2] = b;
    endtask

    // One readout frame: pre ticks with ud_en high, the fall at edge E, then
    // MSB-first bits of w starting at E+SD+1. Optional abort at bit abort_k,
    // optional reset after rst_lanes lane writes.
    task automatic drive_frame(input logic [3:0][15:0] w, input int abort_k,
                               input bit ready_push, input int rst_lanes, input int pre);
        int k;
        ud_en = 1;
        for (int i = 0; i < pre; i++) tick();
        ud_en = 0;
        tick();
        for (int j = 1; j <= SD + FB + 4; j++) begin
            k = j - SD - 1;
            for (int n = 0; n < 4; n++)
                set_line(n, (k >= 0 && k < FB) ? w[n][FB-1-k] : 1'($urandom_range(0, 1)));
            if (k == abort_k) ud_en = 1;
            if (rand_ready) rd_ready = 1'($urandom_range(0, 1));
            else            rd_ready = (ready_push && j > SD + FB) ? 1'b1 : 1'b0;
            tick();
            if (k == abort_k) begin
                chk("abort_pulse", aborted, 1);
                chk("abort_busy",  busy,    0);
                tick();
                chk("abort_one_cycle", aborted, 0);
                rd_ready = 0;
                return;
            end
            if (rst_lanes > 0 && j == SD + FB + rst_lanes) begin
                rstb = 0; ud_en = 0; rd_ready = 0;
                #1;
                model_reset();
                chk_all_zero("midrst");
                tick(); tick();
                rstb = 1;
                return;
            end
            if (j == 21) chk("frame_done_pre", frame_done, 0);
            if (j == 22) chk("frame_done_E22", frame_done, 1);
        end
        rd_ready = 0;
    endtask

    task automatic drain_check(input string tag);
        int got;
        got = 0;
        rd_ready = 1;
        for (int i = 0; i < 12; i++) begin
            if (rd_valid === 1'b1) begin
                if (got < exp_q.size()) chk({tag, "_word"}, rd_data, exp_q[got]);
                got++;
            end
            tick();
        end
        chk({tag, "_count"}, got, exp_q.size());
        rd_ready = 0;
        exp_q.delete();
    endtask

    task automatic expect_frame(input logic [3:0][15:0] w);
        for (int n = 0; n < 4; n++) exp_q.push_back({2'(n), w[n]});
    endtask

    task automatic hard_reset();
        rstb = 0; ud_en = 1; rd_ready = 0;
        #1;
        model_reset();
        tick(); tick();
        rstb = 1;
        tick();
    endtask

    function automatic logic [3:0][15:0] mk(input logic [15:0] a, b, c, d);
        logic [3:0][15:0] r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    typedef struct {
        logic [3:0][15:0] w;
        logic [17:0]      exp_head;
        logic             exp_ovf;
        bit               kept;
    } vec_t;

    vec_t tbl [3];

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0][15:0] fa, fb, fc, fd, fe, fr;
        int ak;

        tbl[0] = '{w: mk(16'hA5C3, 16'h0001, 16'hFFFF, 16'h8000), exp_head: 18'h0A5C3, exp_ovf: 1'b0, kept: 1};
        tbl[1] = '{w: mk(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0), exp_head: 18'h0A5C3, exp_ovf: 1'b0, kept: 1};
        tbl[2] = '{w: mk(16'h1111, 16'h2222, 16'h3333, 16'h4444), exp_head: 18'h0A5C3, exp_ovf: 1'b1, kept: 0};

        rstb = 0; ud_en = 1; rd_ready = 0; read_out_I = 0; read_out_Q = 0;
        ud_z = 1; rdy_z = 0; ri_z = 0; rq_z = 0;
        model_reset();
        #2;
        chk_all_zero("reset");
        tick(); tick(); tick();
        rstb = 1;
        tick();

        // Basic frame and back-pressure across three frames
        for (int i = 0; i < 3; i++) begin
            drive_frame(tbl[i].w, NONE, 0, 0, 1);
            chk("tbl_head", rd_data,  tbl[i].exp_head);
            chk("tbl_ovf",  overflow, tbl[i].exp_ovf);
            if (tbl[i].kept) expect_frame(tbl[i].w);
        end
        drain_check("backpressure");

        // Push and pop together while full
        hard_reset();
        fa = mk(16'h0F0F, 16'hF0F0, 16'h00FF, 16'hFF00);
        fb = mk(16'h1357, 16'h2468, 16'hACE1, 16'hBDF2);
        fc = mk(16'h7777, 16'h8888, 16'h9999, 16'hAAAA);
        drive_frame(fa, NONE, 0, 0, 1);
        drive_frame(fb, NONE, 0, 0, 1);
        chk("full_ovf_before", overflow, 0);
        drive_frame(fc, NONE, 1, 0, 1);
        chk("full_ovf_after", overflow, 0);
        expect_frame(fb);
        expect_frame(fc);
        drain_check("full_pushpop");

        // Abort in SHIFT at bit 5, abort in WAIT, then a normal frame
        fd = mk(16'hC001, 16'h0BAD, 16'hBEEF, 16'h5A5A);
        drive_frame(fd, 5, 0, 0, 1);
        chk("abort_nopush", rd_valid, 0);
        drive_frame(fd, -1, 0, 0, 1);
        chk("abort_wait_nopush", rd_valid, 0);
        drive_frame(fd, NONE, 0, 0, 2);
        expect_frame(fd);
        drain_check("post_abort");

        // Reset during PUSH after two lane writes
        fe = mk(16'h4321, 16'h8765, 16'hCBA9, 16'h0FED);
        drive_frame(fe, NONE, 0, 2, 1);
        ud_en = 0;
        for (int i = 0; i < 25; i++) tick();
        chk("no_start_busy",  busy,     0);
        chk("no_start_valid", rd_valid, 0);
        drive_frame(fe, NONE, 0, 0, 1);
        expect_frame(fe);
        drain_check("post_reset");

        // Randomised frames, aborts, gaps and consumer stalls
        rand_ready = 1;
        for (int f = 0; f < 25; f++) begin
            for (int n = 0; n < 4; n++) fr[n] = 16'($urandom);
            ak = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, SD + FB - 1)) - SD : NONE;
            drive_frame(fr, ak, 0, 0, int'($urandom_range(1, 3)));
        end
        rand_ready = 0;
        ud_en = 1;
        rd_ready = 1;
        for (int i = 0; i < 12; i++) tick();
        rd_ready = 0;

        // START_DELAY = 0 instance: bit 0 at E+1, lane-3 write at E+20
        ud_z = 0;
        tick();
        for (int j = 1; j <= 20; j++) begin
            ri_z[0] = (j == 1);
            tick();
            if (j == 1)  chk("z_busy", busy_z, 1);
            if (j == 16) chk("z_valid_pre", rv_z, 0);
            if (j == 17) begin
                chk("z_valid", rv_z, 1);
                chk("z_lane0", rdat_z, 18'h08000);
            end
            if (j == 19) chk("z_done_pre", fd_z, 0);
            if (j == 20) begin
                chk("z_done",  fd_z,   1);
                chk("z_idle",  busy_z, 0);
                chk("z_abort", ab_z,   0);
                chk("z_ovf",   ov_z,   0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
